// File: rtl/lowend_msgpass_pkg.sv
// Shared definitions for the low-end partial message-passing path:
// sequencer state encodings and lane-count helpers.
package lowend_msgpass_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Frame length clipped to the number of physical combiner lanes.
  function automatic int clamp_len(input int len, input int unit_num);
    return (len > unit_num) ? unit_num : len;
  endfunction

  // Smallest index/length width that can still represent unit_num itself.
  function automatic int cnt_width_for(input int unit_num);
    return $clog2(unit_num + 1);
  endfunction

endpackage

// File: rtl/combiner_load_sequencer_if.sv
// Segment stream in, combiner lane strobes and frame handshake out.
// The sequencer side uses the slave modport.
interface combiner_load_sequencer_if #(
  parameter int UNIT_NUM   = 3,
  parameter int UNIT_WIDTH = 4,
  parameter int CNT_WIDTH  = 2
);
  logic                           frame_start_i;
  logic [CNT_WIDTH-1:0]           cfg_len_i;
  logic [UNIT_WIDTH-1:0]          seg_i;
  logic                           seg_valid_i;
  logic                           seg_ready_o;
  logic                           abort_i;
  logic [UNIT_NUM-1:0]            load_en_o;
  logic [UNIT_NUM*UNIT_WIDTH-1:0] port_in_o;
  logic                           comb_valid_o;
  logic                           comb_ready_i;
  logic [CNT_WIDTH-1:0]           comb_len_o;
  logic                           busy_o;

  modport master (
    output frame_start_i, cfg_len_i, seg_i, seg_valid_i, abort_i, comb_ready_i,
    input  seg_ready_o, load_en_o, port_in_o, comb_valid_o, comb_len_o, busy_o
  );

  modport slave (
    input  frame_start_i, cfg_len_i, seg_i, seg_valid_i, abort_i, comb_ready_i,
    output seg_ready_o, load_en_o, port_in_o, comb_valid_o, comb_len_o, busy_o
  );
endinterface

// File: rtl/combiner_load_sequencer_decoder.sv
// Lane index to one-hot lane strobe, all zero when not enabled.
module onehot_lane_decoder #(
  parameter int UNIT_NUM  = 3,
  parameter int CNT_WIDTH = 2
) (
  input  logic [CNT_WIDTH-1:0] idx,
  input  logic                 en,
  output logic [UNIT_NUM-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < UNIT_NUM; i++) begin
      onehot[i] = en && (idx == CNT_WIDTH'(i));
    end
  end

endmodule

// File: rtl/combiner_load_sequencer.sv
// Fills combiner lanes one segment per cycle in lane order, then holds the
// completed word valid until the downstream consumer acknowledges it.
//
//   state     | meaning
//   ST_IDLE   | no frame; waiting for frame_start_i with nonzero length
//   ST_FILL   | accepting segments, strobing lane idx on each accept
//   ST_HOLD   | combiner holds a complete frame, comb_valid_o asserted
module combiner_load_sequencer
  import lowend_msgpass_pkg::*;
#(
  parameter int UNIT_NUM   = 3,
  parameter int UNIT_WIDTH = 4,
  parameter int CNT_WIDTH  = 2
) (
  input logic                     sys_clk,
  input logic                     rstn,
  combiner_load_sequencer_if.slave bus
);

  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] idx;
  logic [CNT_WIDTH-1:0] len;
  logic [CNT_WIDTH-1:0] len_clamped;
  logic                 accept;
  logic                 start_ok;
  logic                 last_seg;

  assign len_clamped = CNT_WIDTH'(clamp_len(int'(bus.cfg_len_i), UNIT_NUM));
  assign start_ok    = bus.frame_start_i && (bus.cfg_len_i != '0);
  assign last_seg    = (idx == len - CNT_WIDTH'(1));

  // Ready depends only on state and abort, never on seg_valid_i.
  assign bus.seg_ready_o  = (state == ST_FILL) && !bus.abort_i;
  assign accept           = bus.seg_valid_i && bus.seg_ready_o;
  assign bus.port_in_o    = {UNIT_NUM{bus.seg_i}};
  assign bus.comb_valid_o = (state == ST_HOLD);
  assign bus.comb_len_o   = len;
  assign bus.busy_o       = (state != ST_IDLE);

  onehot_lane_decoder #(
    .UNIT_NUM  (UNIT_NUM),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_decoder (
    .idx    (idx),
    .en     (accept),
    .onehot (bus.load_en_o)
  );

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
      idx   <= '0;
      len   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state <= ST_FILL;
            len   <= len_clamped;
            idx   <= '0;
          end
        end
        ST_FILL: begin
          if (bus.abort_i) begin
            state <= ST_IDLE;
            idx   <= '0;
          end else if (accept) begin
            if (last_seg) begin
              state <= ST_HOLD;
              idx   <= '0;
            end else begin
              idx <= idx + CNT_WIDTH'(1);
            end
          end
        end
        ST_HOLD: begin
          if (bus.abort_i) begin
            state <= ST_IDLE;
            idx   <= '0;
          end else if (bus.comb_ready_i) begin
            // Chained start skips the idle bubble between frames.
            if (start_ok) begin
              state <= ST_FILL;
              len   <= len_clamped;
              idx   <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/combiner_load_sequencer.md
# combiner_load_sequencer

Sequencer that fills the `data_bus_combiner` lane latches one segment per cycle from a narrow valid/ready segment stream. It generates the per-lane `load_en` strobes in lane order for a configurable frame length (1..UNIT_NUM lanes). Once the last lane is latched, it presents the combined word as valid to the downstream partial-message-passing logic and holds it until acknowledged. It sits directly in front of `data_bus_combiner` in the low-end partial message-passing path.

## Interface
- UNIT_NUM, 3, number of combiner lanes
- UNIT_WIDTH, 4, bits per lane/segment
- CNT_WIDTH, 2, width of lane index/length; must satisfy 2^CNT_WIDTH > UNIT_NUM
- sys_clk  in  1  single clock, all state on rising edge
- rstn  in  1  reset; synchronous, active-low
- frame_start_i  in  1  begin a frame; samples cfg_len_i
- cfg_len_i  in  CNT_WIDTH  segments in frame
- seg_i  in  UNIT_WIDTH  incoming segment
- seg_valid_i  in  1  segment valid
- seg_ready_o  out  1  segment accepted when valid&ready
- abort_i  in  1  discard current frame
- load_en_o  out  UNIT_NUM  to combiner load_en_i
- port_in_o  out  UNIT_NUM*UNIT_WIDTH  to combiner port_in_i; seg_i replicated on every lane
- comb_valid_o  out  1  combiner output holds a complete frame
- comb_ready_i  in  1  downstream consumed frame
- comb_len_o  out  CNT_WIDTH  valid lane count of the held frame; lanes ≥ comb_len_o are stale
- busy_o  out  1  state != IDLE

## Operation
- States: IDLE, FILL, HOLD.
- IDLE:
  - On frame_start_i with cfg_len_i != 0: latch len = min(cfg_len_i, UNIT_NUM), clear idx to 0, go to FILL.
  - cfg_len_i == 0: ignore, stay in IDLE.
- FILL:
  - seg_ready_o = 1 (combinational, = state==FILL & !abort_i).
  - On accept: load_en_o = one-hot(idx), idx++.
  - If idx == len-1 on accept: go to HOLD.
- HOLD:
  - comb_valid_o = 1; no loads occur, so combiner contents are stable.
  - On comb_ready_i: go to IDLE.
  - If frame_start_i is also high with valid cfg_len_i: go directly to FILL with new len and idx=0 (no bubble).
- load_en_o = one-hot(idx) & {UNIT_NUM{seg_valid_i & seg_ready_o}}; zero in all other cases.
- abort_i in FILL or HOLD:
  - Next state IDLE, idx=0.
  - abort overrides a same-cycle final accept and a same-cycle comb_ready_i/frame_start_i.
  - No load_en_o fires in the abort cycle.
- abort_i in IDLE has no effect. frame_start_i in FILL is ignored.
- comb_len_o = registered len; holds its value until the next frame start.

## Timing
- Reset (rstn=0 at an edge): state=IDLE, idx=0, len=0. Consequently seg_ready_o=0, load_en_o=0, comb_valid_o=0, comb_len_o=0, busy_o=0.
- rstn overrides abort_i and all other inputs. Reset mid-frame drops the frame; combiner reset is driven separately by the same rstn.
- seg_ready_o and load_en_o are combinational from state, idx, seg_valid_i and abort_i; there is no seg_valid_i → seg_ready_o path.
- Latency:
  - Last segment accepted in cycle t; combiner latch updates at the end of t.
  - comb_valid_o = 1 from cycle t+1 (registered HOLD state), aligned with combiner port_out_o.
- Throughput: one segment per cycle. A frame of N segments with an immediately-ready consumer and back-to-back frame_start takes N+1 cycles per frame.
- seg_valid_i gaps in FILL stall idx; there is no timeout.

## Structure
- Shared package `lowend_msgpass_pkg`:
  - state enum {IDLE, FILL, HOLD}
  - clamp function min(len, UNIT_NUM)
  - CNT_WIDTH derivation helper (clog2(UNIT_NUM+1))
- Sub-module `onehot_lane_decoder` (idx → UNIT_NUM-bit one-hot, gated by enable). The combiner itself is instantiated by the parent, not here.

## Test plan
- Full frame: UNIT_NUM=3, frame_start with cfg_len=3, segs 0xA,0xB,0xC on consecutive cycles -> load_en_o 001,010,100; comb_valid_o rises the cycle after 0xC; combiner out 0xCBA; comb_len_o=3.
- Partial frame plus stall: cfg_len=2, seg_valid_i low for 2 cycles between segs -> idx holds, only 001 then 010 fire, HOLD reached after 2nd accept, comb_len_o=2.
- Clamp/zero: cfg_len=0 -> stays IDLE, busy_o=0. cfg_len=3 with UNIT_NUM=2 -> len=2.
- Back-pressure and back-to-back: hold comb_ready_i low 5 cycles -> comb_valid_o stays 1, seg_ready_o 0, no load_en_o. Then comb_ready_i&frame_start_i -> FILL next cycle, seg_ready_o=1.
- Abort: abort_i on the final-segment cycle -> load_en_o=0 that cycle, next state IDLE, comb_valid_o never asserts.
- Reset mid-frame: rstn=0 after 1 accepted segment -> next cycle all outputs 0, state IDLE; new frame then starts cleanly at lane 0.
